ov7670_stream_gen: RTL
======================

# ov7670_stream_gen

Synthesizable OV7670 camera emulator: produces VSYNC, HREF and the 8-bit RGB565 byte stream with the same framing as the real sensor, one byte per clock. It drives `camera_read` in place of the physical camera for bring-up and regression of the capture → SDRAM → VGA path. It also gives benches a deterministic frame source. Data comes from internal test patterns or from an external pixel stream through a valid/ready handshake.

## Interface
- `p_h_active`, 640: active pixels per line; must be divisible by 8.
- `p_v_active`, 480: active lines per frame.
- `p_h_blank`, 288: HREF-low byte clocks after the active bytes of every line.
- `p_vsync_lines`, 3: lines with VSYNC high.
- `p_v_back`, 17: blank lines between VSYNC low and the first active line.
- `p_v_front`, 10: blank lines after the last active line.

- `i_clk`, in, 1: byte clock; all logic on the rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_enable`, in, 1: level; run frames while high.
- `i_pattern`, in, 2: 0 colour bars, 1 ramp, 2 counter, 3 external stream.
- `i_pix_valid`, in, 1: external pixel valid.
- `i_pix_data`, in, 16: external RGB565 pixel.
- `o_pix_ready`, out, 1: external pixel accepted this cycle if `i_pix_valid` is high.
- `o_vsync`, out, 1: frame sync, active high.
- `o_href`, out, 1: high while `o_data` carries active bytes.
- `o_data`, out, 8: pixel byte, high byte first.
- `o_frame_done`, out, 1: one-cycle pulse at end of frame.
- `o_underflow`, out, 1: sticky; external pixel missing when needed.

## Operation
- L = 2·p_h_active + p_h_blank cycles per line; a frame is p_vsync_lines + p_v_back + p_v_active + p_v_front lines.
- States:
  - IDLE: all outputs 0. When `i_enable`=1 → VSYNC; `i_pattern` is latched on this transition.
  - VSYNC: `o_vsync`=1 for p_vsync_lines·L cycles → VBACK.
  - VBACK: p_v_back·L cycles → ACTIVE.
  - ACTIVE: for each of p_v_active lines, `o_href`=1 for 2·p_h_active cycles, then 0 for p_h_blank cycles → VFRONT.
  - VFRONT: p_v_front·L cycles. On its last cycle `o_frame_done`=1; then go to VSYNC (relatch pattern) if `i_enable`=1, else IDLE.
- Deasserting `i_enable` mid-frame has no effect until the frame completes.
- Counters: byte counter 0..L−1 wraps each line. Line counter is per state. Pixel column `col` and row `row` count from 0 at each line and frame respectively.
- Byte order: even byte = pixel[15:8], odd byte = pixel[7:0]. `o_data`=0 whenever `o_href`=0.
- Patterns:
  - 0: 8 bars of p_h_active/8 pixels each: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1: pixel = {row[4:0], col[5:0], col[4:0]}.
  - 2: 16-bit counter, cleared at VSYNC entry, incremented per pixel, wraps FFFF→0000.
  - 3: external stream. `o_pix_ready` pulses once per pixel, on the cycle before that pixel's high byte appears. If `i_pix_valid`=0 then, the pixel is 0000 and `o_underflow` is set.
- `o_underflow` is cleared only by reset. `o_pix_ready`=0 in patterns 0–2.
- Reset, including mid-frame: next cycle is IDLE, all outputs 0, counters 0.

## Timing
- All outputs registered.
- `i_enable` rising in IDLE at edge n → `o_vsync`=1 from cycle n+1.
- The first `o_href` rises (p_vsync_lines+p_v_back)·L cycles after `o_vsync` rises.
- The external pixel accepted at cycle k has its high byte on `o_data` at k+1 and its low byte at k+2.
- Back-to-back frames: `o_vsync` rises the cycle after `o_frame_done`, with no gap.

## Test plan
All scenarios use p_h_active=8, p_v_active=4, p_h_blank=4, p_vsync_lines=1, p_v_back=1, p_v_front=1 (L=20, frame 140 cycles).

- **Framing:** reset, `i_enable`=1, pattern 0. Require `o_vsync` high 20 cycles, then 20 idle cycles, then 4 lines of 16 HREF-high + 4 low. Require `o_frame_done` at cycle 140 and `o_vsync` again at 141.
- **Colour bars:** first line bytes are FF,FF, FF,E0, 07,FF, 07,E0, F8,1F, F8,00, 00,1F, 00,00.
- **Counter pattern:** pattern 2 over two frames gives bytes 00,00 … 00,1F in each frame (restart at 0000). `o_data`=0 in every blank cycle.
- **External stream:** pattern 3, always-valid source of 1234, 5678, … Require `o_pix_ready` one cycle before each pixel's high byte, output 12,34,56,78, and `o_underflow`=0. Then drop valid for one pixel: require 00,00 for that pixel and `o_underflow` stuck at 1 until reset.
- **Enable drop:** drop `i_enable` mid-ACTIVE. The frame completes and `o_frame_done` pulses, then the block goes to IDLE with outputs 0.
- **Mid-frame reset:** assert `i_rst` mid-line. Next cycle all outputs are 0. After release with `i_enable`=1, a full correct frame follows.

Source files
------------

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670-style VSYNC/HREF/RGB565 byte stream generator with test patterns or an external pixel source
module ov7670_stream_gen #(
    parameter int P_H_ACTIVE    = 640,
    parameter int P_V_ACTIVE    = 480,
    parameter int P_H_BLANK     = 288,
    parameter int P_VSYNC_LINES = 3,
    parameter int P_V_BACK      = 17,
    parameter int P_V_FRONT     = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern,
    input  logic        i_pix_valid,
    input  logic [15:0] i_pix_data,
    output logic        o_pix_ready,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_frame_done,
    output logic        o_underflow
);
    localparam int L   = 2 * P_H_ACTIVE + P_H_BLANK;
    localparam int BW  = $clog2(L);
    localparam int CW  = BW - 1;
    localparam int LW  = 16;
    localparam int BAR = P_H_ACTIVE / 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_VSYNC = 3'd1, S_VBACK = 3'd2, S_ACTIVE = 3'd3, S_VFRONT = 3'd4;
    localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                         16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
    logic [2:0]    r_state;
    logic [BW-1:0] r_byte;
    logic [LW-1:0] r_line;
    logic [1:0]    r_pat;
    logic [15:0]   r_cnt;
    logic [7:0]    r_lo;
    logic          w_eol, w_last, w_href, w_even, w_ready;
    logic [2:0]    w_nstate;
    logic [BW-1:0] w_nbyte;
    logic [LW-1:0] w_nline;
    logic [CW-1:0] w_col;
    logic [5:0]    w_c6;
    logic [2:0]    w_bar;
    logic [15:0]   w_px;
    // The w_n* signals describe the cycle about to be presented, so every output is a plain flop.
    always_comb begin
        w_eol    = r_byte == BW'(L - 1);
        w_last   = r_state == S_VSYNC  ? r_line == LW'(P_VSYNC_LINES - 1) :
                   r_state == S_VBACK  ? r_line == LW'(P_V_BACK - 1) :
                   r_state == S_ACTIVE ? r_line == LW'(P_V_ACTIVE - 1) :
                                         r_line == LW'(P_V_FRONT - 1);
        w_nstate = r_state == S_IDLE   ? (i_enable ? S_VSYNC : S_IDLE) :
                   !(w_eol && w_last)  ? r_state :
                   r_state == S_VSYNC  ? S_VBACK :
                   r_state == S_VBACK  ? S_ACTIVE :
                   r_state == S_ACTIVE ? S_VFRONT :
                   (i_enable ? S_VSYNC : S_IDLE);
        w_nbyte  = (r_state == S_IDLE || w_eol) ? '0 : r_byte + 1'b1;
        w_nline  = w_nstate != r_state ? '0 : w_eol ? r_line + 1'b1 : r_line;
        w_href   = w_nstate == S_ACTIVE && w_nbyte < BW'(2 * P_H_ACTIVE);
        w_even   = w_href && !w_nbyte[0];
        w_col    = w_nbyte[BW-1:1];
        w_c6     = 6'(w_col);
        w_bar    = 3'(w_col / CW'(BAR));
        w_px     = r_pat == 2'd0 ? BARS[w_bar] :
                   r_pat == 2'd1 ? {w_nline[4:0], w_c6, w_c6[4:0]} :
                   r_pat == 2'd2 ? r_cnt :
                   (i_pix_valid ? i_pix_data : 16'h0000);
        w_ready  = r_pat == 2'd3 &&
                   ((w_nstate == S_ACTIVE && w_nbyte[0] && w_nbyte < BW'(2 * P_H_ACTIVE - 1)) ||
                    (w_nbyte == BW'(L - 1) &&
                     ((w_nstate == S_VBACK && w_nline == LW'(P_V_BACK - 1)) ||
                      (w_nstate == S_ACTIVE && w_nline != LW'(P_V_ACTIVE - 1)))));
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_byte       <= '0;
            r_line       <= '0;
            r_pat        <= '0;
            r_cnt        <= '0;
            r_lo         <= '0;
            o_pix_ready  <= 1'b0;
            o_vsync      <= 1'b0;
            o_href       <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_byte  <= w_nbyte;
            r_line  <= w_nline;
            if (w_nstate == S_VSYNC && r_state != S_VSYNC) begin
                r_pat <= i_pattern;
                r_cnt <= '0;
            end else if (w_even) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_even)
                r_lo <= w_px[7:0];
            o_pix_ready  <= w_ready;
            o_vsync      <= w_nstate == S_VSYNC;
            o_href       <= w_href;
            o_data       <= !w_href ? 8'h00 : w_nbyte[0] ? r_lo : w_px[15:8];
            o_frame_done <= w_nstate == S_VFRONT && w_nline == LW'(P_V_FRONT - 1) && w_nbyte == BW'(L - 1);
            o_underflow  <= o_underflow | (o_pix_ready & ~i_pix_valid);
        end
    end
endmodule
